// File: rtl/l2_mem_write_buffer.sv
// Write-back buffer between L2 and main memory: queues evictions, forwards reads, one memory op at a time.
// Optional WBUF_COALESCE_EN merges a write into a queued entry with the same address.
module l2_mem_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    l2_addrstb,
   input  logic                    l2_we,
   input  logic [ADDR_W-1:0]       l2_addr,
   input  logic [DATA_W-1:0]       l2_wdata,
   output logic [DATA_W-1:0]       l2_rdata,
   output logic                    l2_done,
   output logic                    l2_stall,
   output logic                    mem_addrstb,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   input  logic [DATA_W-1:0]       mem_rdata,
   input  logic                    mem_stb,
   output logic [$clog2(DEPTH):0]  wbuf_count
);

   // state    | meaning
   // IDLE     | no memory transaction outstanding
   // WR_ISSUE | head write strobed to memory this cycle
   // WR_WAIT  | waiting for memory to commit the head write
   // RD_ISSUE | read-miss strobed to memory this cycle
   // RD_WAIT  | waiting for memory read data
   typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT} state_t;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = ADDR_W - 3;

   state_t            state;
   logic [TW-1:0]     tagMem  [DEPTH];
   logic [DATA_W-1:0] dataMem [DEPTH];
   logic [PW-1:0]     headPtr, tailPtr;
   logic              rdBusy;
   logic [TW-1:0]     rdTag;

   logic [TW-1:0]     reqTag, missTag;
   logic              hitAny;
   logic [DATA_W-1:0] hitData, drainData;
   logic              coalesce, wrAccept, rdAccept, rdMiss, push, pop;
   logic              rdBusyNext, startRead;
   logic [CW-1:0]     countNext;
   logic              unusedAddrBits;

   assign unusedAddrBits = ^l2_addr[2:0];
   assign reqTag = l2_addr[ADDR_W-1:3];

`ifdef WBUF_COALESCE_EN
   logic          coalHit, coalWrite, headInFlight;
   logic [PW-1:0] coalIdx;
   assign headInFlight = (state == WR_ISSUE) || (state == WR_WAIT);
`endif

   // Later (younger) matches overwrite earlier ones, so the youngest entry wins.
   always_comb begin
      hitAny  = 1'b0;
      hitData = '0;
`ifdef WBUF_COALESCE_EN
      coalHit = 1'b0;
      coalIdx = '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < wbuf_count && tagMem[headPtr + PW'(i)] == reqTag) begin
            hitAny  = 1'b1;
            hitData = dataMem[headPtr + PW'(i)];
`ifdef WBUF_COALESCE_EN
            if (!(headInFlight && i == 0)) begin
               coalHit = 1'b1;
               coalIdx = headPtr + PW'(i);
            end
`endif
         end
      end
   end

`ifdef WBUF_COALESCE_EN
   assign coalesce  = l2_we & coalHit;
   assign coalWrite = wrAccept & coalesce;
   // A merge into the head on the very edge it is issued must reach memory.
   assign drainData = (coalWrite && coalIdx == headPtr) ? l2_wdata : dataMem[headPtr];
`else
   assign coalesce  = 1'b0;
   assign drainData = dataMem[headPtr];
`endif

   assign wrAccept   = l2_addrstb & l2_we & (~l2_stall | (coalesce & ~rdBusy));
   assign rdAccept   = l2_addrstb & ~l2_we & ~l2_stall;
   assign rdMiss     = rdAccept & ~hitAny;
   assign push       = wrAccept & ~coalesce;
   assign pop        = (state == WR_WAIT) & mem_stb;
   assign countNext  = wbuf_count + CW'(push) - CW'(pop);
   assign rdBusyNext = rdMiss | (rdBusy & ~((state == RD_WAIT) & mem_stb));
   assign startRead  = rdBusy | rdMiss;
   assign missTag    = rdBusy ? rdTag : reqTag;

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (push) begin
            tagMem[tailPtr]  <= reqTag;
            dataMem[tailPtr] <= l2_wdata;
         end
`ifdef WBUF_COALESCE_EN
         if (coalWrite)
            dataMem[coalIdx] <= l2_wdata;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         headPtr     <= '0;
         tailPtr     <= '0;
         wbuf_count  <= '0;
         rdBusy      <= 1'b0;
         rdTag       <= '0;
         l2_rdata    <= '0;
         l2_done     <= 1'b0;
         l2_stall    <= 1'b0;
         mem_addrstb <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         l2_done     <= 1'b0;
         mem_addrstb <= 1'b0;
         if (push)
            tailPtr <= tailPtr + 1'b1;
         if (pop)
            headPtr <= headPtr + 1'b1;
         if (wrAccept)
            l2_done <= 1'b1;
         if (rdAccept && hitAny) begin
            l2_done  <= 1'b1;
            l2_rdata <= hitData;
         end
         if (rdMiss)
            rdTag <= reqTag;
         wbuf_count <= countNext;
         rdBusy     <= rdBusyNext;
         l2_stall   <= (countNext == CW'(DEPTH)) | rdBusyNext;

         case (state)
            IDLE: begin
               if (startRead) begin
                  state       <= RD_ISSUE;
                  mem_addrstb <= 1'b1;
                  mem_we      <= 1'b0;
                  mem_addr    <= {missTag, 3'b000};
               end else if (wbuf_count != '0) begin
                  state       <= WR_ISSUE;
                  mem_addrstb <= 1'b1;
                  mem_we      <= 1'b1;
                  mem_addr    <= {tagMem[headPtr], 3'b000};
                  mem_wdata   <= drainData;
               end
            end
            WR_ISSUE: state <= WR_WAIT;
            WR_WAIT: begin
               // A waiting read miss goes out right after the write commits.
               if (mem_stb) begin
                  if (startRead) begin
                     state       <= RD_ISSUE;
                     mem_addrstb <= 1'b1;
                     mem_we      <= 1'b0;
                     mem_addr    <= {missTag, 3'b000};
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            RD_ISSUE: state <= RD_WAIT;
            RD_WAIT: begin
               if (mem_stb) begin
                  l2_rdata <= mem_rdata;
                  l2_done  <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_mem_write_buffer.sv
// Bench for l2_mem_write_buffer: directed scenarios then random traffic against a queue-level model.
// Build with +define+WBUF_COALESCE_EN to exercise the coalescing variant.
module tb_l2_mem_write_buffer;
   localparam int DEPTH = 4;
`ifdef WBUF_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        l2_addrstb, l2_we, l2_done, l2_stall;
   logic [31:0] l2_addr, mem_addr;
   logic [63:0] l2_wdata, l2_rdata, mem_wdata, mem_rdata;
   logic        mem_addrstb, mem_we, mem_stb;
   logic [2:0]  wbuf_count;

   always #5 clk = ~clk;

   l2_mem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(64)) dut (
      .clk(clk), .reset(reset),
      .l2_addrstb(l2_addrstb), .l2_we(l2_we), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
      .l2_rdata(l2_rdata), .l2_done(l2_done), .l2_stall(l2_stall),
      .mem_addrstb(mem_addrstb), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_stb(mem_stb), .wbuf_count(wbuf_count)
   );

   typedef struct packed {logic [31:0] a; logic [63:0] d;} ent_t;
   ent_t        q[$];
   logic [63:0] memArr [logic [31:0]];
   logic [31:0] issueLog[$];
   int          nCmp = 0, nBad = 0, cyc = 0;
   bit          rdOut, expDone, expRd, txnPend, txnWe, memHold, injStb;
   logic [31:0] rdAddr, txnA;
   logic [63:0] expData;
   int          txnAt, memLatMax = 2, wrCommitCyc, rdIssueCyc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nBad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] memRead(input logic [31:0] a);
      return memArr.exists(a) ? memArr[a] : {a, ~a};
   endfunction

   function automatic int youngest(input logic [31:0] a, input bit skipHead);
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].a == a && !(skipHead && i == 0)) return i;
      return -1;
   endfunction

   // One clock cycle: apply a request, update the model, then check the registered outputs.
   task automatic tick(input logic stb, input logic we, input logic [31:0] a, input logic [63:0] d);
      logic [31:0] al;
      bit full, inFlight, acc;
      int ci, hi;
      al = a & ~32'h7;
      full = (q.size() == DEPTH);
      inFlight = txnPend && txnWe;
      ci = COAL ? youngest(al, inFlight) : -1;
      acc = stb && !rdOut && (we ? (!full || ci >= 0) : !full);
      l2_addrstb = stb; l2_we = we; l2_addr = a; l2_wdata = d;
      mem_stb = 1'b0; mem_rdata = {$urandom, $urandom};
      expDone = 1'b0;
      if (acc && we) begin
         expDone = 1'b1; expRd = 1'b0;
         if (ci >= 0) q[ci].d = d;
         else q.push_back(ent_t'{a: al, d: d});
      end else if (acc) begin
         hi = youngest(al, 1'b0);
         if (hi >= 0) begin
            expDone = 1'b1; expRd = 1'b1; expData = q[hi].d;
         end else begin
            rdOut = 1'b1; rdAddr = al;
         end
      end
      if (injStb) begin
         mem_stb = 1'b1;
      end else if (txnPend && !memHold && cyc >= txnAt) begin
         mem_stb = 1'b1;
         if (txnWe) begin
            memArr[q[0].a] = q[0].d;
            wrCommitCyc = cyc;
            void'(q.pop_front());
         end else begin
            mem_rdata = memRead(rdAddr);
            expDone = 1'b1; expRd = 1'b1; expData = mem_rdata;
            rdOut = 1'b0;
         end
         txnPend = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      chk("done", l2_done, expDone);
      if (expDone && expRd) chk("rdata", l2_rdata, expData);
      chk("count", wbuf_count, q.size());
      chk("stall", l2_stall, (q.size() == DEPTH) || rdOut);
      if (mem_addrstb) begin
         chk("one_outstanding", txnPend, 0);
         issueLog.push_back(mem_addr);
         if (mem_we) begin
            chk("drain_nonempty", q.size() > 0, 1);
            if (q.size() > 0) begin
               chk("drain_addr", mem_addr, q[0].a);
               chk("drain_data", mem_wdata, q[0].d);
            end
         end else begin
            chk("rd_pending", rdOut, 1);
            chk("rd_addr", mem_addr, rdAddr);
            rdIssueCyc = cyc;
         end
         txnPend = 1'b1; txnWe = mem_we; txnA = mem_addr;
         txnAt = cyc + 1 + $urandom_range(0, memLatMax);
      end
   endtask

   task automatic idleUntilEmpty(input int maxCyc);
      int n = 0;
      while ((q.size() > 0 || rdOut || txnPend) && n < maxCyc) begin
         tick(0, 0, 0, 0);
         n++;
      end
      chk("drain_timeout", n < maxCyc, 1);
      tick(0, 0, 0, 0);
   endtask

   task automatic applyReset();
      reset = 1'b1;
      l2_addrstb = 0; l2_we = 0; l2_addr = 0; l2_wdata = 0; mem_stb = 0; mem_rdata = 0;
      @(posedge clk); #1;
      cyc++;
      reset = 1'b0;
      q.delete(); rdOut = 0; txnPend = 0; expDone = 0; memHold = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      reset = 1'b1; injStb = 0;
      applyReset();
      applyReset();
      chk("rst_rdata", l2_rdata, 0);
      chk("rst_done", l2_done, 0);
      chk("rst_stall", l2_stall, 0);
      chk("rst_mstb", mem_addrstb, 0);
      chk("rst_mwe", mem_we, 0);
      chk("rst_maddr", mem_addr, 0);
      chk("rst_mwdata", mem_wdata, 0);
      chk("rst_count", wbuf_count, 0);

      // single write drains two cycles after acceptance
      tick(1, 1, 32'h100, 64'hA5A5_0000_0000_0001);
      tick(0, 0, 0, 0);
      chk("t1_mstb", mem_addrstb, 1);
      chk("t1_mwe", mem_we, 1);
      chk("t1_maddr", mem_addr, 32'h100);
      idleUntilEmpty(20);
      chk("t1_count0", wbuf_count, 0);

      // fill with memory held busy, then a strobe while full is ignored
      memHold = 1;
      tick(1, 1, 32'h000, 64'h10);
      tick(1, 1, 32'h008, 64'h11);
      tick(1, 1, 32'h010, 64'h12);
      tick(1, 1, 32'h018, 64'h13);
      chk("t2_stall", l2_stall, 1);
      tick(1, 1, 32'h020, 64'h14);
      chk("t2_no_done", l2_done, 0);
      chk("t2_count4", wbuf_count, 4);
      memHold = 0;
      idleUntilEmpty(60);

      // read hit forwarded from the buffer
      tick(1, 1, 32'h200, 64'hDEAD);
      tick(1, 0, 32'h200, 0);
      chk("t3_rdata", l2_rdata, 64'hDEAD);
      idleUntilEmpty(20);

      // read miss bypasses the second queued write
      issueLog.delete();
      memHold = 1;
      tick(1, 1, 32'h400, 64'h1);
      tick(1, 1, 32'h408, 64'h2);
      tick(0, 0, 0, 0);
      tick(1, 0, 32'h300, 0);
      memHold = 0;
      c = 0;
      while (txnPend && txnWe && c < 20) begin tick(0, 0, 0, 0); c++; end
      c = wrCommitCyc;
      idleUntilEmpty(60);
      chk("t4_issues", issueLog.size(), 3);
      if (issueLog.size() >= 3) begin
         chk("t4_first", issueLog[0], 32'h400);
         chk("t4_read", issueLog[1], 32'h300);
         chk("t4_second", issueLog[2], 32'h408);
      end
      chk("t4_rd_latency", rdIssueCyc - c, 1);

      // reset in WR_WAIT with three queued, then a stray mem_stb
      memHold = 1;
      tick(1, 1, 32'h500, 64'h5);
      tick(1, 1, 32'h508, 64'h6);
      tick(1, 1, 32'h510, 64'h7);
      tick(0, 0, 0, 0);
      chk("t5_count3", wbuf_count, 3);
      applyReset();
      chk("t5_count0", wbuf_count, 0);
      injStb = 1;
      tick(0, 0, 0, 0);
      injStb = 0;
      chk("t5_no_done", l2_done, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      chk("t5_idle", mem_addrstb, 0);

      // same-address writes: merged or both kept, youngest data wins
      memHold = 1;
      tick(1, 1, 32'h40, 64'h1);
      tick(1, 1, 32'h40, 64'h2);
      tick(0, 0, 0, 0);
      chk("t6_count", wbuf_count, COAL ? 1 : 2);
      tick(1, 0, 32'h40, 0);
      chk("t6_rdata", l2_rdata, 64'h2);
      memHold = 0;
      idleUntilEmpty(60);

      memLatMax = 3;
      for (int i = 0; i < 1500; i++)
         tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              32'h1000 + 32'($urandom_range(0, 7)) * 8 + 32'($urandom_range(0, 7)),
              {$urandom, $urandom});
      idleUntilEmpty(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
